// File: rtl/cm_pkg.sv
// Shared types and helpers for the cm_* scheduling blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: scheduler FSM state enum, arbiter selection algorithm enum,
// and sclog2(), a clog2 that never returns less than 1 (safe for index widths).
package cm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    GRANT
  } t_sched_state;

  typedef enum logic {
    ARB_MAX,
    ARB_MIN
  } t_arb_algo;

  function automatic int sclog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cm_arbiter.sv
// Pipelined weighted arbiter: picks the requester with the max (or min) weight.
// Latency: REG_CNT cycles from i_req/i_dat to o_vld/o_gnt.
// Backpressure: none; one result per launched request vector, no stalls.
//
// Ports:
//   i_clk, i_rst    clock, asynchronous active-low reset
//   i_req [DCNT]    request vector sampled this cycle
//   i_dat           packed per-requester weights, DWIDTH bits each
//   o_vld           a result is presented this cycle
//   o_gnt           index of the winning requester
module cm_arbiter
  import cm_pkg::*;
#(
  parameter int        DCNT    = 4,
  parameter int        DWIDTH  = 5,
  parameter int        REG_CNT = 2,
  parameter t_arb_algo ALGO    = ARB_MAX
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [DCNT-1:0]          i_req,
  input  logic [DCNT*DWIDTH-1:0]   i_dat,
  output logic                     o_vld,
  output logic [sclog2(DCNT)-1:0]  o_gnt
);

  localparam int IW = sclog2(DCNT);

  logic              sel_vld;
  logic [IW-1:0]     sel_idx;
  logic [DWIDTH-1:0] best;
  logic [DWIDTH-1:0] cur;
  logic              better;

  // Linear scan; a strict compare keeps the lowest index on ties.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    best    = '0;
    cur     = '0;
    better  = 1'b0;
    for (int i = 0; i < DCNT; i++) begin
      cur    = i_dat[i*DWIDTH +: DWIDTH];
      better = (ALGO == ARB_MAX) ? (cur > best) : (cur < best);
      if (i_req[i] && (!sel_vld || better)) begin
        sel_vld = 1'b1;
        sel_idx = IW'(i);
        best    = cur;
      end
    end
  end

  logic          vld_q [REG_CNT];
  logic [IW-1:0] idx_q [REG_CNT];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int s = 0; s < REG_CNT; s++) begin
        vld_q[s] <= 1'b0;
        idx_q[s] <= '0;
      end
    end else begin
      vld_q[0] <= sel_vld;
      idx_q[0] <= sel_idx;
      for (int s = 1; s < REG_CNT; s++) begin
        vld_q[s] <= vld_q[s-1];
        idx_q[s] <= idx_q[s-1];
      end
    end
  end

  assign o_vld = vld_q[REG_CNT-1];
  assign o_gnt = idx_q[REG_CNT-1];

endmodule

// File: rtl/cm_age_sched.sv
// Aging priority scheduler: one shared resource, weight {prio, age} per requester.
// Latency: launch -> grant visible after REG_CNT+1 cycles; release -> grant drop in 1.
// Backpressure: grant held until i_rel (or hold timeout); requests wait while busy.
//
// Ports:
//   i_clk, i_rst  clock, asynchronous active-low reset
//   i_req         per-requester request level
//   i_prio        packed static priority per requester, higher wins
//   i_rel         owner releases the resource (pulse, honoured in GRANT only)
//   o_gnt         one-hot grant, o_gnt_idx its index
//   o_busy        scheduler not idle
//   o_timeout     one-cycle pulse on forced release
// Build option: define CM_AGE_SCHED_TIMEOUT_EN to force release after HOLD_MAX
// grant cycles; otherwise the grant is held indefinitely and o_timeout is 0.
module cm_age_sched
  import cm_pkg::*;
#(
  parameter int DCNT     = 4,
  parameter int PWIDTH   = 2,
  parameter int AWIDTH   = 3,
  parameter int REG_CNT  = 2,
  parameter int HOLD_MAX = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [DCNT-1:0]          i_req,
  input  logic [DCNT*PWIDTH-1:0]   i_prio,
  input  logic                     i_rel,
  output logic [DCNT-1:0]          o_gnt,
  output logic [sclog2(DCNT)-1:0]  o_gnt_idx,
  output logic                     o_busy,
  output logic                     o_timeout
);

  localparam int             IW      = sclog2(DCNT);
  localparam int             DW      = PWIDTH + AWIDTH;
  localparam logic [AWIDTH-1:0] AGE_MAX = '1;

  t_sched_state      state_q, state_d;
  logic [AWIDTH-1:0] age_q [DCNT];

  logic [DCNT-1:0]    arb_req;
  logic [DCNT*DW-1:0] arb_dat;
  logic               arb_vld;
  logic [IW-1:0]      arb_idx;

  logic               cap;
  logic               rel;
  logic               hold_expire;
  logic [DCNT-1:0]    gnt_onehot;

  always_comb begin
    arb_dat = '0;
    for (int i = 0; i < DCNT; i++) begin
      arb_dat[i*DW +: DW] = {i_prio[i*PWIDTH +: PWIDTH], age_q[i]};
    end
  end

  cm_arbiter #(
    .DCNT    (DCNT),
    .DWIDTH  (DW),
    .REG_CNT (REG_CNT),
    .ALGO    (ARB_MAX)
  ) u_arb (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_req (arb_req),
    .i_dat (arb_dat),
    .o_vld (arb_vld),
    .o_gnt (arb_idx)
  );

  // The arbiter only sees requests in the single launch cycle, so exactly one
  // result is in flight while in WAIT. The winner is re-validated against the
  // live request vector because it may have dropped during the pipeline delay.
  always_comb begin
    state_d = state_q;
    arb_req = '0;
    cap     = 1'b0;
    rel     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|i_req) begin
          arb_req = i_req;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (arb_vld) begin
          if (i_req[arb_idx]) begin
            cap     = 1'b1;
            state_d = GRANT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GRANT: begin
        if (i_rel || hold_expire) begin
          rel     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_onehot          = '0;
    gnt_onehot[arb_idx] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      o_gnt     <= '0;
      o_gnt_idx <= '0;
      o_busy    <= 1'b0;
      for (int i = 0; i < DCNT; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      o_busy  <= (state_d != IDLE);
      if (cap) begin
        o_gnt     <= gnt_onehot;
        o_gnt_idx <= arb_idx;
        // Winner restarts; waiting requesters age; absent ones lose history.
        for (int i = 0; i < DCNT; i++) begin
          if (IW'(i) == arb_idx) begin
            age_q[i] <= '0;
          end else if (i_req[i]) begin
            age_q[i] <= (age_q[i] == AGE_MAX) ? age_q[i] : age_q[i] + 1'b1;
          end else begin
            age_q[i] <= '0;
          end
        end
      end else if (rel) begin
        o_gnt     <= '0;
        o_gnt_idx <= '0;
      end
    end
  end

`ifdef CM_AGE_SCHED_TIMEOUT_EN
  localparam int HW = sclog2(HOLD_MAX);

  logic [HW-1:0] hold_cnt;

  // A release on the limit cycle wins, so no timeout pulse in that case.
  assign hold_expire = (state_q == GRANT) && (hold_cnt == HW'(HOLD_MAX - 1)) && !i_rel;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      hold_cnt  <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= hold_expire;
      if (state_q == GRANT) begin
        hold_cnt <= hold_cnt + 1'b1;
      end else begin
        hold_cnt <= '0;
      end
    end
  end
`else
  logic unused_hold_max;

  assign unused_hold_max = |32'(HOLD_MAX);
  assign hold_expire     = 1'b0;
  assign o_timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_cm_age_sched.sv
// Directed bench for cm_age_sched with DCNT=4, PWIDTH=2, AWIDTH=3, REG_CNT=2.
// Latency: n/a.
// Backpressure: n/a.
module tb_cm_age_sched;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic [3:0] i_req = '0;
  logic [7:0] i_prio = '0;
  logic       i_rel = 1'b0;
  logic [3:0] o_gnt;
  logic [1:0] o_gnt_idx;
  logic       o_busy;
  logic       o_timeout;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rel_cyc  = 0;

  cm_age_sched #(
    .DCNT     (4),
    .PWIDTH   (2),
    .AWIDTH   (3),
    .REG_CNT  (2),
    .HOLD_MAX (5)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_req     (i_req),
    .i_prio    (i_prio),
    .i_rel     (i_rel),
    .o_gnt     (o_gnt),
    .o_gnt_idx (o_gnt_idx),
    .o_busy    (o_busy),
    .o_timeout (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic wait_gnt(input int lim);
    int n;
    n = 0;
    while (o_gnt == 4'b0000 && n < lim) begin
      tick();
      n++;
    end
    chk("gnt_arrive", {31'd0, (o_gnt != 4'b0000)}, 32'd1);
  endtask

  // Wait for a grant, check it, release one cycle later with new inputs.
  task automatic do_round(input string tag, input int exp_idx, input logic [3:0] nreq,
                          input logic [7:0] nprio, input bit chk_lat);
    wait_gnt(12);
    if (chk_lat) chk({tag, "_lat"}, cyc - rel_cyc, 32'd4);
    chk({tag, "_idx"}, {30'd0, o_gnt_idx}, exp_idx);
    chk({tag, "_gnt"}, {28'd0, o_gnt}, 32'd1 << exp_idx);
    tick();
    i_rel   = 1'b1;
    i_req   = nreq;
    i_prio  = nprio;
    rel_cyc = cyc;
    tick();
    i_rel = 1'b0;
    chk({tag, "_relclr"}, {28'd0, o_gnt}, 32'd0);
  endtask

  int exp_rot [5] = '{0, 1, 2, 3, 0};
  int bad;

  initial begin
    // Reset values
    tick();
    tick();
    chk("rst_gnt", {28'd0, o_gnt}, 32'd0);
    chk("rst_idx", {30'd0, o_gnt_idx}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_timeout", {31'd0, o_timeout}, 32'd0);
    i_rst = 1'b1;
    tick();

    // Single request: launch at cycle 0, grant at cycle 3, release at 5
    i_req = 4'b0100;
    tick();
    chk("single_busy_c1", {31'd0, o_busy}, 32'd1);
    chk("single_gnt_c1", {28'd0, o_gnt}, 32'd0);
    tick();
    chk("single_gnt_c2", {28'd0, o_gnt}, 32'd0);
    tick();
    chk("single_gnt_c3", {28'd0, o_gnt}, 32'h4);
    chk("single_idx_c3", {30'd0, o_gnt_idx}, 32'd2);
    i_req = 4'b0000;
    tick();
    chk("single_hold_c4", {28'd0, o_gnt}, 32'h4);
    tick();
    i_rel = 1'b1;
    tick();
    i_rel = 1'b0;
    chk("single_gnt_c6", {28'd0, o_gnt}, 32'd0);
    chk("single_busy_c6", {31'd0, o_busy}, 32'd0);

    // Stale: request only in launch cycle
    tick();
    i_req = 4'b0010;
    tick();
    i_req = 4'b0000;
    chk("stale_busy_c1", {31'd0, o_busy}, 32'd1);
    tick();
    chk("stale_busy_c2", {31'd0, o_busy}, 32'd1);
    tick();
    chk("stale_busy_c3", {31'd0, o_busy}, 32'd0);
    chk("stale_gnt_c3", {28'd0, o_gnt}, 32'd0);

    // Rotation among equal priorities: 0,1,2,3,0
    tick();
    i_req  = 4'b1111;
    i_prio = 8'h00;
    for (int r = 0; r < 5; r++) begin
      do_round("rot", exp_rot[r], (r == 4) ? 4'b0000 : 4'b1111, 8'h00, r > 0);
    end
    // Ages now {a3,a2,a1,a0} = {1,2,3,0}

    // Priority dominance: requester 3 at prio 3 wins every round
    i_req  = 4'b1111;
    i_prio = 8'b11_00_00_00;
    for (int r = 0; r < 10; r++) begin
      do_round("prio", 3, (r == 9) ? 4'b0111 : 4'b1111, (r == 9) ? 8'h00 : 8'b11_00_00_00, r > 0);
    end
    // Ages 0..2 saturated at 7: equal weights, lowest index wins
    wait_gnt(12);
    chk("sat_idx", {30'd0, o_gnt_idx}, 32'd0);
    tick();
    tick();
    chk("sat_hold", {28'd0, o_gnt}, 32'h1);

    // Asynchronous reset in the middle of GRANT
    i_rst = 1'b0;
    i_req = 4'b0000;
    #1;
    chk("midrst_gnt", {28'd0, o_gnt}, 32'd0);
    chk("midrst_busy", {31'd0, o_busy}, 32'd0);
    chk("midrst_idx", {30'd0, o_gnt_idx}, 32'd0);
    tick();
    i_rst = 1'b1;
    tick();
    i_req = 4'b1111;
    wait_gnt(12);
    chk("postrst_idx", {30'd0, o_gnt_idx}, 32'd0);
    i_req = 4'b0000;

`ifdef CM_AGE_SCHED_TIMEOUT_EN
    // Forced release after 5 grant cycles
    bad = 0;
    for (int k = 1; k < 5; k++) begin
      tick();
      if (o_gnt != 4'b0001 || o_timeout != 1'b0) bad++;
    end
    chk("to_hold", bad, 32'd0);
    tick();
    chk("to_gnt_drop", {28'd0, o_gnt}, 32'd0);
    chk("to_pulse", {31'd0, o_timeout}, 32'd1);
    tick();
    chk("to_pulse_end", {31'd0, o_timeout}, 32'd0);

    // Release coinciding with the limit is a normal release
    i_req = 4'b0001;
    wait_gnt(12);
    i_req = 4'b0000;
    tick();
    tick();
    tick();
    tick();
    i_rel = 1'b1;
    tick();
    i_rel = 1'b0;
    chk("relim_gnt", {28'd0, o_gnt}, 32'd0);
    chk("relim_pulse", {31'd0, o_timeout}, 32'd0);
`else
    // No timeout: grant held for 100 cycles
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (o_gnt != 4'b0001 || o_timeout != 1'b0) bad++;
    end
    chk("hold100", bad, 32'd0);
    chk("hold100_busy", {31'd0, o_busy}, 32'd1);
    i_rel = 1'b1;
    tick();
    i_rel = 1'b0;
    chk("hold100_rel", {28'd0, o_gnt}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cm_age_sched.md
# cm_age_sched

Aging priority scheduler that shares one resource among `DCNT` requesters using the pipelined `cm_arbiter` (ARB_MAX) as its selection engine. Each arbitration weight is `{static priority, age}`, so equal-priority requesters rotate and no one starves within a priority level. The block sequences the pipelined arbiter (launch, wait, validate), holds a grant until the owner releases it, and maintains per-requester age counters. It sits in front of any shared `lib_cm` datapath resource.

## Interface
- `DCNT`, 4: number of requesters, ≥2
- `PWIDTH`, 2: static priority width
- `AWIDTH`, 3: age counter width
- `REG_CNT`, 2: arbiter pipeline latency, ≥1
- `HOLD_MAX`, 16: maximum grant hold in cycles (timeout build only), ≥1
- `i_clk`  in  1  clock
- `i_rst`  in  1  asynchronous, active-low reset
- `i_req`  in  DCNT  per-requester request level
- `i_prio`  in  DCNT×PWIDTH  static priority; higher wins
- `i_rel`  in  1  owner releases resource (pulse)
- `o_gnt`  out  DCNT  one-hot grant, held until release
- `o_gnt_idx`  out  sclog2(DCNT)  index of granted requester
- `o_busy`  out  1  state ≠ IDLE
- `o_timeout`  out  1  one-cycle pulse on forced release (timeout build only, else tied 0)

## Operation
- FSM states: IDLE, WAIT, GRANT.
- IDLE: if |i_req, launch: arbiter sees `i_req` and weights `{i_prio[i], age[i]}` this cycle only; clear WAIT counter; go to WAIT. Otherwise the arbiter request input is 0.
- WAIT: arbiter request input forced 0. On arbiter `o_vld`, with winner idx:
  - i_req[idx]=1 → register grant, apply age update, go to GRANT.
  - i_req[idx]=0 (stale) → no grant, ages unchanged, go to IDLE.
- GRANT: o_gnt/o_gnt_idx constant. i_rel=1 → clear grant, go to IDLE. Requester dropping i_req does not release. i_rel in IDLE/WAIT is ignored.
- Age update at grant capture: winner age ← 0; every other requester with i_req=1 ← age+1, saturating at 2^AWIDTH−1; requesters with i_req=0 ← 0.
- Winner = max `{prio, age}`; ties go to the lowest index.
- Reset (any state, asynchronous): state IDLE, all ages 0, o_gnt=0, o_gnt_idx=0, o_busy=0, o_timeout=0. The arbiter pipeline is reset by the same signal, so no result survives reset.

## Timing
- Launch at cycle 0 → arbiter o_vld at cycle REG_CNT → o_gnt visible at cycle REG_CNT+1.
- i_rel at cycle t → o_gnt=0 at t+1; state IDLE at t+1. A relaunch is possible at t+1, so the next grant is at t+REG_CNT+2.
- A stale result returns to IDLE at REG_CNT+1. The next launch is at REG_CNT+1.
- o_busy is registered from state: high from cycle 1 after launch until the cycle after release.

## Configuration
- `CM_AGE_SCHED_TIMEOUT_EN` defined:
  - A grant-hold counter runs in GRANT.
  - After HOLD_MAX cycles with o_gnt asserted and no i_rel, the grant is cleared exactly as for i_rel, and o_timeout pulses for one cycle, coincident with o_gnt falling.
  - i_rel on the same cycle as the limit counts as a normal release: no pulse.
- Undefined: no counter; the grant is held indefinitely; o_timeout is tied 0.

## Structure
- `cm_pkg`: add `t_sched_state` enum (IDLE, WAIT, GRANT).
- Widths derive locally from `sclog2`.
- One sub-module: `cm_arbiter` instance with DCNT, DWIDTH=PWIDTH+AWIDTH, REG_CNT, ALGO=ARB_MAX. Its o_gnt is the winner idx.

## Test plan
All scenarios use DCNT=4, PWIDTH=2, AWIDTH=3, REG_CNT=2.
- Reset: assert i_rst low mid-GRANT → o_gnt=0000, o_busy=0 immediately; after deassert, ages are 0 (verified by the next 1111 arbitration granting idx 0).
- Single request: i_req=0100 at cycle 0 → o_gnt=0100, o_gnt_idx=2 at cycle 3; i_rel at cycle 5 → o_gnt=0000 at cycle 6.
- Rotation: i_req=1111, prio all 0, i_rel one cycle after each grant → grant order 0,1,2,3,0.
- Priority dominance: i_prio[3]=3, others 0, i_req=1111 → idx 3 granted every round; ages 0..2 saturate at 7 and never win.
- Stale: i_req=0010 at cycle 0 only → no grant, o_busy high cycles 1–2, IDLE at cycle 3.
- Timeout (macro on, HOLD_MAX=5): grant with i_rel never asserted → o_gnt drops after 5 grant cycles, o_timeout=1 for exactly that cycle; macro off → grant held for 100 cycles.
